// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: N valid/ready streams onto one registered register-file write port
// with load lane alignment and extension. Define WB_BYPASS_EN to add same-cycle bypass outputs.
module writeback_arbiter #(
  parameter int XLEN           = 32,
  parameter int NUM_SOURCES    = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SOURCES-1:0]              in_valid,
  output logic [NUM_SOURCES-1:0]              in_ready,
  input  logic [2*NUM_SOURCES-1:0]            in_kind,
  input  logic [REG_ADDR_WIDTH*NUM_SOURCES-1:0] in_rd,
  input  logic [XLEN*NUM_SOURCES-1:0]         in_data,
  input  logic [3*NUM_SOURCES-1:0]            in_funct3,
  input  logic [3*NUM_SOURCES-1:0]            in_byte_off,
  output logic                                wr_enable,
  output logic [REG_ADDR_WIDTH-1:0]           wr_address,
  output logic [XLEN-1:0]                     wr_data
`ifdef WB_BYPASS_EN
  ,
  output logic                                bypass_valid,
  output logic [REG_ADDR_WIDTH-1:0]           bypass_rd,
  output logic [XLEN-1:0]                     bypass_data
`endif
);

  localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [PTR_W-1:0]          rr_q, rr_d;
  logic                      wr_enable_q, wr_enable_d;
  logic [REG_ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
  logic [XLEN-1:0]           wr_data_q, wr_data_d;

  logic [NUM_SOURCES-1:0]    writer, silent, gnt_oh;
  logic                      gnt_any;
  logic [PTR_W-1:0]          gnt_idx;
  logic [1:0]                gnt_kind;
  logic [REG_ADDR_WIDTH-1:0] gnt_rd;
  logic [XLEN-1:0]           gnt_data;

  function automatic int wrap_idx(input int base, input int step);
    int idx;
    idx = base + step;
    if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
    return idx;
  endfunction

  // Upper lanes shifted out read as zero; only log2(XLEN/8) offset bits are meaningful.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] raw,
                                                  input logic [2:0] funct3,
                                                  input logic [2:0] off);
    logic [2:0]      off_eff;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    off_eff = off & ((XLEN == 64) ? 3'b111 : 3'b011);
    sh      = raw >> {off_eff, 3'b000};
    case (funct3)
      3'b000:  res = XLEN'($signed(sh[7:0]));
      3'b001:  res = XLEN'($signed(sh[15:0]));
      3'b011:  res = (XLEN == 64) ? sh : XLEN'($signed(sh[31:0]));
      3'b100:  res = XLEN'(sh[7:0]);
      3'b101:  res = XLEN'(sh[15:0]);
      3'b110:  res = XLEN'(sh[31:0]);
      default: res = XLEN'($signed(sh[31:0]));
    endcase
    return res;
  endfunction

  always_comb begin
    writer  = '0;
    silent  = '0;
    gnt_oh  = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (rst && in_valid[i]) begin
        if ((in_kind[2*i +: 2] == 2'b01 || in_kind[2*i +: 2] == 2'b10) &&
            in_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0)
          writer[i] = 1'b1;
        else
          silent[i] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (!gnt_any && writer[wrap_idx(int'(rr_q), k)]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(wrap_idx(int'(rr_q), k));
      end
    end
    gnt_oh[gnt_idx] = gnt_any;
    in_ready        = silent | gnt_oh;

    gnt_kind = in_kind[int'(gnt_idx)*2 +: 2];
    gnt_rd   = in_rd[int'(gnt_idx)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    gnt_data = (gnt_kind == 2'b10)
             ? format_load(in_data[int'(gnt_idx)*XLEN +: XLEN],
                           in_funct3[int'(gnt_idx)*3 +: 3],
                           in_byte_off[int'(gnt_idx)*3 +: 3])
             : in_data[int'(gnt_idx)*XLEN +: XLEN];

    wr_enable_d  = gnt_any;
    wr_address_d = gnt_any ? gnt_rd : wr_address_q;
    wr_data_d    = gnt_any ? gnt_data : wr_data_q;
    rr_d         = rr_q;
    if (gnt_any)
      rr_d = (int'(gnt_idx) == NUM_SOURCES - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Registered write stage; async reset also drops any grant in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q         <= '0;
      wr_enable_q  <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
    end else begin
      rr_q         <= rr_d;
      wr_enable_q  <= wr_enable_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_enable  = wr_enable_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;

`ifdef WB_BYPASS_EN
  assign bypass_valid = gnt_any;
  assign bypass_rd    = gnt_rd;
  assign bypass_data  = gnt_data;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (XLEN=32, two sources); bypass checks when WB_BYPASS_EN is defined.
module tb_writeback_arbiter;
  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int RAW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     in_valid, in_ready;
  logic [2*NS-1:0]   in_kind;
  logic [RAW*NS-1:0] in_rd;
  logic [XLEN*NS-1:0] in_data;
  logic [3*NS-1:0]   in_funct3, in_byte_off;
  logic              wr_enable;
  logic [RAW-1:0]    wr_address;
  logic [XLEN-1:0]   wr_data;
`ifdef WB_BYPASS_EN
  logic              bypass_valid;
  logic [RAW-1:0]    bypass_rd;
  logic [XLEN-1:0]   bypass_data;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  writeback_arbiter #(.XLEN(XLEN), .NUM_SOURCES(NS), .REG_ADDR_WIDTH(RAW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
    .in_data(in_data), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
    .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data)
`ifdef WB_BYPASS_EN
    , .bypass_valid(bypass_valid), .bypass_rd(bypass_rd), .bypass_data(bypass_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int s, input logic v, input logic [1:0] k, input logic [4:0] rd,
                         input logic [31:0] d, input logic [2:0] f3, input logic [2:0] off);
    in_valid[s]           = v;
    in_kind[2*s +: 2]     = k;
    in_rd[RAW*s +: RAW]   = rd;
    in_data[XLEN*s +: XLEN] = d;
    in_funct3[3*s +: 3]   = f3;
    in_byte_off[3*s +: 3] = off;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [2:0] f3; logic [2:0] off; logic [31:0] exp; string tag; } load_vec_t;
  load_vec_t lv[9];

  logic [1:0]  cont_rdy[4];
  logic [4:0]  cont_adr[4];
  logic [31:0] cont_dat[4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lv[0] = '{3'b000, 3'd1, 32'h0000007F, "lb_off1"};
    lv[1] = '{3'b000, 3'd2, 32'hFFFFFFFF, "lb_off2"};
    lv[2] = '{3'b100, 3'd3, 32'h00000080, "lbu_off3"};
    lv[3] = '{3'b001, 3'd2, 32'hFFFF80FF, "lh_off2"};
    lv[4] = '{3'b101, 3'd0, 32'h00007F01, "lhu_off0"};
    lv[5] = '{3'b010, 3'd1, 32'h0080FF7F, "lw_misaligned"};
    lv[6] = '{3'b011, 3'd0, 32'h80FF7F01, "ld_as_lw"};
    lv[7] = '{3'b110, 3'd2, 32'h000080FF, "lwu_as_lw"};
    lv[8] = '{3'b100, 3'd4, 32'h00000001, "lbu_off_bit2_ignored"};
    cont_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    cont_adr = '{5'd5, 5'd6, 5'd5, 5'd6};
    cont_dat = '{32'h11, 32'h22, 32'h11, 32'h22};

    // Reset held with both sources requesting
    rst = 1'b0;
    in_valid = '0; in_kind = '0; in_rd = '0; in_data = '0; in_funct3 = '0; in_byte_off = '0;
    set_src(0, 1'b1, 2'b01, 5'd5, 32'h11, 3'b0, 3'b0);
    set_src(1, 1'b1, 2'b01, 5'd6, 32'h22, 3'b0, 3'b0);
    #2;
    check_val("rst_ready", in_ready, 2'b00);
    check_val("rst_wr_en", wr_enable, 1'b0);
    tick(); tick();
    check_val("rst_wr_en_held", wr_enable, 1'b0);
    check_val("rst_wr_addr", wr_address, 5'd0);
    check_val("rst_wr_data", wr_data, 32'd0);

    // Contention: alternation starting at source 0, twice
    rst = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("cont_ready_%0d", c), in_ready, cont_rdy[c]);
      tick();
      check_val($sformatf("cont_wr_en_%0d", c), wr_enable, 1'b1);
      check_val($sformatf("cont_addr_%0d", c), wr_address, cont_adr[c]);
      check_val($sformatf("cont_data_%0d", c), wr_data, cont_dat[c]);
    end
    set_src(0, 1'b0, 2'b01, 5'd5, 32'h11, 3'b0, 3'b0);
    set_src(1, 1'b0, 2'b01, 5'd6, 32'h22, 3'b0, 3'b0);
    tick();
    check_val("idle_wr_en", wr_enable, 1'b0);
    check_val("idle_addr_hold", wr_address, 5'd6);
    check_val("idle_data_hold", wr_data, 32'h22);

    // Load alignment and extension on source 0
    for (int i = 0; i < 9; i++) begin
      set_src(0, 1'b1, 2'b10, 5'd3, 32'h80FF7F01, lv[i].f3, lv[i].off);
      tick();
      check_val({lv[i].tag, "_en"}, wr_enable, 1'b1);
      check_val(lv[i].tag, wr_data, lv[i].exp);
    end
    set_src(0, 1'b1, 2'b01, 5'd3, 32'h80FF7F01, 3'b000, 3'd1);
    tick();
    check_val("result_passthru", wr_data, 32'h80FF7F01);

    // Silent entries: kind 00 on src0, rd 0 on src1
    set_src(0, 1'b1, 2'b00, 5'd4, 32'h44, 3'b0, 3'b0);
    set_src(1, 1'b1, 2'b01, 5'd0, 32'h55, 3'b0, 3'b0);
    #1;
    check_val("silent_ready", in_ready, 2'b11);
    tick();
    check_val("silent_wr_en", wr_enable, 1'b0);
    check_val("silent_data_hold", wr_data, 32'h80FF7F01);

    // Silent (kind 11) alongside a writer on the other source
    set_src(0, 1'b1, 2'b11, 5'd4, 32'h44, 3'b0, 3'b0);
    set_src(1, 1'b1, 2'b01, 5'd9, 32'h99, 3'b0, 3'b0);
    #1;
    check_val("mixed_ready", in_ready, 2'b11);
    tick();
    check_val("mixed_wr_en", wr_enable, 1'b1);
    check_val("mixed_addr", wr_address, 5'd9);
    check_val("mixed_data", wr_data, 32'h99);

    // Same rd from both sources: serialised, pointer back at 0
    set_src(0, 1'b1, 2'b01, 5'd8, 32'hA, 3'b0, 3'b0);
    set_src(1, 1'b1, 2'b01, 5'd8, 32'hB, 3'b0, 3'b0);
    #1;
    check_val("samerd_ready0", in_ready, 2'b01);
    tick();
    check_val("samerd_data0", wr_data, 32'hA);
    check_val("samerd_ready1", in_ready, 2'b10);
    tick();
    check_val("samerd_addr1", wr_address, 5'd8);
    check_val("samerd_data1", wr_data, 32'hB);

    // Mid-stream async reset drops the pending rd 7 grant
    set_src(0, 1'b0, 2'b01, 5'd8, 32'hA, 3'b0, 3'b0);
    set_src(1, 1'b1, 2'b01, 5'd7, 32'h77, 3'b0, 3'b0);
    #1;
    check_val("midrst_grant", in_ready, 2'b10);
    rst = 1'b0;
    #1;
    check_val("midrst_wr_en_now", wr_enable, 1'b0);
    check_val("midrst_ready", in_ready, 2'b00);
    check_val("midrst_addr_now", wr_address, 5'd0);
    tick();
    check_val("midrst_wr_en_edge", wr_enable, 1'b0);
    check_val("midrst_addr_edge", wr_address, 5'd0);

    // Single grant after release (bypass visible in the grant cycle when enabled)
    set_src(1, 1'b0, 2'b01, 5'd7, 32'h77, 3'b0, 3'b0);
    set_src(0, 1'b1, 2'b01, 5'd9, 32'h1234, 3'b0, 3'b0);
    rst = 1'b1;
    #1;
    check_val("post_rst_ready", in_ready, 2'b01);
`ifdef WB_BYPASS_EN
    check_val("byp_valid", bypass_valid, 1'b1);
    check_val("byp_rd", bypass_rd, 5'd9);
    check_val("byp_data", bypass_data, 32'h1234);
`endif
    tick();
    check_val("post_rst_wr_en", wr_enable, 1'b1);
    check_val("post_rst_addr", wr_address, 5'd9);
    check_val("post_rst_data", wr_data, 32'h1234);
    set_src(0, 1'b0, 2'b01, 5'd9, 32'h1234, 3'b0, 3'b0);
    #1;
`ifdef WB_BYPASS_EN
    check_val("byp_valid_idle", bypass_valid, 1'b0);
`endif
    tick();
    check_val("final_wr_en", wr_enable, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Parametrised successor to the single-source writeback stage. Accepts up to NUM_SOURCES completed-instruction streams, for example the ALU/JAL path and a late load path. Each stream uses a valid/ready handshake. The block arbitrates round-robin onto the single register-file write port, performs load byte-lane alignment and sign/zero extension, and drives a registered write with 1-cycle latency.

Parameters:
XLEN, 32, register and data width (32 or 64)
NUM_SOURCES, 2, number of input streams (1..4)
REG_ADDR_WIDTH, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  NUM_SOURCES  per-source entry valid
in_ready  out  NUM_SOURCES  per-source entry consumed this cycle
in_kind  in  2*NUM_SOURCES  per source: 00 no-write, 01 result, 10 load, 11 reserved (treated as 00)
in_rd  in  REG_ADDR_WIDTH*NUM_SOURCES  destination register
in_data  in  XLEN*NUM_SOURCES  result, or raw memory word for loads
in_funct3  in  3*NUM_SOURCES  load width/sign (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110)
in_byte_off  in  3*NUM_SOURCES  load address low bits (only log2(XLEN/8) LSBs used)
wr_enable  out  1  register-file write enable
wr_address  out  REG_ADDR_WIDTH  write address
wr_data  out  XLEN  write data

Behaviour:
- Reset (rst low, async): wr_enable=0, wr_address=0, wr_data=0, rr_pointer=0. in_ready is combinational and is 0 while rst is low.
- Entries with kind 00/11, or with rd==0, are "silent":
  - in_ready=1 whenever valid (and rst high).
  - Consumed with no write.
  - Never take part in arbitration.
- Writing entries (kind 01/10, rd!=0) compete.
  - Grant goes to the first requester at or after rr_pointer, searching upward with wrap.
  - Exactly one in_ready is asserted among writing requesters.
  - Losers hold their inputs stable until granted; inputs must not change while valid && !ready.
- rr_pointer update: after a grant to source g, rr_pointer = (g+1) mod NUM_SOURCES. With no grant it holds.
- Output register: on the clock edge after a grant, wr_enable=1, wr_address=rd, wr_data=formatted data. In a cycle with no grant, wr_enable=0; address and data hold their previous values.
- Throughput: one write per cycle, back-to-back.
- Result kind: wr_data = in_data unchanged.
- Load kind:
  - Shift in_data right by 8*byte_off bits, then extend per funct3.
  - Byte loads: sign-extend bit 7 (LB) or zero-extend (LBU).
  - Halfword loads: sign-extend bit 15 (LH) or zero-extend (LHU).
  - LW: sign-extends bit 31 when XLEN=64; when XLEN=32 the value passes as-is.
  - LD/LWU: valid only when XLEN=64. When XLEN=32 they are treated as LW.
  - Misaligned offset: shifted-out upper lanes read as zero. No trap is raised; misalignment is handled upstream.
- Simultaneous requests:
  - A silent entry and a writing entry on different sources are both consumed in the same cycle.
  - Two writers on the same rd in the same cycle are serialised in round-robin order; the later grant wins in the register file.
- NUM_SOURCES=1: the arbiter degenerates to pass-through, with in_ready=valid.
- Reset asserted mid-stream clears the output register immediately; any pending in-flight grant is dropped.

Optional Feature:
WB_BYPASS_EN:
- When defined, adds three ports: bypass_valid (out, 1), bypass_rd (out, REG_ADDR_WIDTH) and bypass_data (out, XLEN).
- These present the granted entry combinationally in the same cycle as the grant, so execute can forward one cycle earlier than the registered write.
- bypass_valid=0 when there is no grant or rst is low.
- When undefined, the ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst low with in_valid=all 1 -> wr_enable=0, in_ready=0. Release rst -> first grant goes to source 0.
- Contention: both sources valid with kind=01, rd=5/data=0x11 and rd=6/data=0x22, held for 2 cycles -> writes (5,0x11) then (6,0x22) on consecutive cycles. Repeat -> order alternates starting at source 0 again (pointer wrapped).
- Load alignment: XLEN=32, data=0x80FF7F01.
  - LB with off=1 -> 0x0000007F.
  - LB with off=2 -> 0xFFFFFFFF.
  - LBU with off=3 -> 0x00000080.
  - LH with off=2 -> 0xFFFF80FF.
  - LHU with off=0 -> 0x00007F01.
- Silent entries: source 0 kind=00 and source 1 kind=01 rd=0, both valid -> both in_ready=1 in the same cycle; wr_enable stays 0.
- Mid-stream reset: grant source 1 (rd=7), then assert rst async before the next edge -> wr_enable=0 immediately, no write of rd 7.
- With WB_BYPASS_EN: single grant rd=9 data=0x1234 -> bypass_valid=1, bypass_rd=9, bypass_data=0x1234 in the grant cycle; wr_enable=1 the following cycle.
